hack_cpu: RTL and testbench

Single-cycle Hack-architecture CPU core (nand2tetris): decodes one 16-bit instruction per clock, holds the A, D and program-counter registers, computes the Hack ALU function, and drives the data-memory interface. It sits between instruction ROM (addressed by `pc`) and data RAM (addressed by `addressM`). It contains no memories; `instr` and `inM` are supplied combinationally by the surrounding computer.

---
 rtl/hack_cpu.sv | 88 ++++++++
 tb/tb_hack_cpu.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/hack_cpu.sv
// Single-cycle Hack CPU core: A/D/PC registers, Hack ALU, jump logic and data-memory port.
// Optional: define HACK_CPU_OUTM_GATE_EN to force outM to zero on cycles that do not write RAM.
module hack_cpu (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic [15:0] inM,
  output logic        writeM,
  output logic [14:0] pc,
  output logic [14:0] addressM,
  output logic [15:0] outM
);

  logic [15:0] regA;
  logic [15:0] regD;
  logic [14:0] regPc;

  logic        isC;
  logic        selM;
  logic        zx, nx, zy, ny, fAdd, no;
  logic        destA, destD, destM;
  logic [2:0]  jmp;

  logic [15:0] aluX;
  logic [15:0] aluY;
  logic [15:0] aluOut;
  logic        zr;
  logic        ng;
  logic        jump;

  assign isC   = instr[15];
  assign selM  = instr[12];
  assign zx    = instr[11];
  assign nx    = instr[10];
  assign zy    = instr[9];
  assign ny    = instr[8];
  assign fAdd  = instr[7];
  assign no    = instr[6];
  assign destA = instr[5];
  assign destD = instr[4];
  assign destM = instr[3];
  assign jmp   = instr[2:0];

  // NOTE: every variable driven here gets a value before any conditional update, so no latch is inferred.
  always_comb begin
    aluX = regD;
    aluY = selM ? inM : regA;
    if (zx) aluX = 16'h0000;
    if (nx) aluX = ~aluX;
    if (zy) aluY = 16'h0000;
    if (ny) aluY = ~aluY;
    aluOut = fAdd ? (aluX + aluY) : (aluX & aluY);
    if (no) aluOut = ~aluOut;
  end

  assign zr   = (aluOut == 16'h0000);
  assign ng   = aluOut[15];
  assign jump = isC & ((jmp[2] & ng) | (jmp[1] & zr) | (jmp[0] & ~ng & ~zr));

  assign writeM   = isC & destM & ~reset;
  assign pc       = regPc;
  assign addressM = regA[14:0];

`ifdef HACK_CPU_OUTM_GATE_EN
  assign outM = writeM ? aluOut : 16'h0000;
`else
  assign outM = aluOut;
`endif

  // The jump target is the pre-edge A, even when the same instruction reloads A.
  // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regA  <= 16'h0000;
      regD  <= 16'h0000;
      regPc <= 15'h0000;
    end else begin
      if (!isC) begin
        regA <= {1'b0, instr[14:0]};
      end else begin
        if (destA) regA <= aluOut;
        if (destD) regD <= aluOut;
      end
      regPc <= jump ? regA[14:0] : regPc + 15'd1;
    end
  end

endmodule

// File: tb/tb_hack_cpu.sv
// Scoreboard bench for hack_cpu: a spec-level reference model predicts each cycle's outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_hack_cpu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] instr = 16'h0000;
  logic [15:0] inM = 16'h0000;
  logic        writeM;
  logic [14:0] pc;
  logic [14:0] addressM;
  logic [15:0] outM;

  hack_cpu dut (
    .clk(clk), .reset(reset), .instr(instr), .inM(inM),
    .writeM(writeM), .pc(pc), .addressM(addressM), .outM(outM)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          step;
    logic [14:0] pc;
    logic [14:0] addr;
    logic        wr;
    logic [15:0] out;
  } expect_t;

  expect_t scoreQ[$];
  int      numChecks = 0;
  int      numErrors = 0;
  int      stepNo = 0;

  // Reference model state
  int unsigned mA = 0;
  int unsigned mD = 0;
  int unsigned mPc = 0;

  task automatic check(input string name, input int stepIdx, input logic [15:0] actual,
                       input logic [15:0] required);
    numChecks++;
    if (actual !== required) begin
      numErrors++;
      $display("FAIL %s step=%0d got=%h want=%h", name, stepIdx, actual, required);
    end
  endtask

  // Hack ALU from its definition, using plain integer arithmetic (~v as 65535-v).
  function automatic int unsigned refAlu(input int unsigned x0, input int unsigned y0,
                                         input logic [5:0] c);
    int unsigned x, y, r;
    x = c[5] ? 0 : x0;
    if (c[4]) x = 65535 - x;
    y = c[3] ? 0 : y0;
    if (c[2]) y = 65535 - y;
    r = c[1] ? (x + y) % 65536 : (x & y);
    if (c[0]) r = 65535 - r;
    return r;
  endfunction

  task automatic step(input logic rst, input logic [15:0] ins, input logic [15:0] mem);
    expect_t     e;
    int unsigned r;
    int          sv;
    bit          isC, doJump;
    @(posedge clk);
    #1;
    reset = rst;
    instr = ins;
    inM   = mem;
    if (rst) begin
      mA = 0; mD = 0; mPc = 0;
    end
    isC = ins[15];
    r  = refAlu(mD, ins[12] ? int'(mem) : mA, ins[11:6]);
    sv = (r >= 32768) ? int'(r) - 65536 : int'(r);
    e.step = stepNo;
    e.pc   = mPc[14:0];
    e.addr = mA[14:0];
    e.wr   = isC && ins[3] && !rst;
`ifdef HACK_CPU_OUTM_GATE_EN
    e.out  = e.wr ? r[15:0] : 16'h0000;
`else
    e.out  = r[15:0];
`endif
    scoreQ.push_back(e);
    stepNo++;
    if (!rst) begin
      doJump = isC && ((ins[2] && sv < 0) || (ins[1] && sv == 0) || (ins[0] && sv > 0));
      mPc = doJump ? (mA % 32768) : (mPc + 1) % 32768;
      if (!isC) mA = ins & 16'h7FFF;
      else begin
        if (ins[5]) mA = r;
        if (ins[4]) mD = r;
      end
    end
  endtask

  always @(negedge clk) begin
    if (scoreQ.size() > 0) begin
      expect_t e;
      e = scoreQ.pop_front();
      check("pc",       e.step, {1'b0, pc},       {1'b0, e.pc});
      check("addressM", e.step, {1'b0, addressM}, {1'b0, e.addr});
      check("writeM",   e.step, {15'd0, writeM},  {15'd0, e.wr});
      check("outM",     e.step, outM,             e.out);
    end
  end

  initial begin
    logic [15:0] ri;
    // Reset held across two edges with arbitrary instructions
    step(1'b1, 16'hFFFF, 16'h1234);
    step(1'b1, 16'hE308, 16'h5555);
    // Directed program from the test plan
    step(1'b0, 16'h3039, 16'h0000);   // @12345
    step(1'b0, 16'hEC10, 16'h0000);   // D=A
    step(1'b0, 16'h03E9, 16'h0000);   // @1001
    step(1'b0, 16'hE308, 16'h0000);   // M=D
    step(1'b0, 16'hF4D0, 16'd11111);  // D=D-M -> 1234
    step(1'b0, 16'hE302, 16'h0000);   // D;JEQ not taken
    step(1'b0, 16'h3039, 16'h0000);   // @12345
    step(1'b0, 16'hEC10, 16'h0000);   // D=A
    step(1'b0, 16'h000E, 16'h0000);   // @14
    step(1'b0, 16'hE301, 16'h0000);   // D;JGT taken
    step(1'b0, 16'hE304, 16'h0000);   // D;JLT not taken
    step(1'b0, 16'hEA87, 16'h0000);   // 0;JMP
    step(1'b0, 16'h0015, 16'h0000);   // @21
    step(1'b0, 16'hE7F7, 16'h0000);   // AD=D+1;JMP -> pc=21, A=D+1
    step(1'b0, 16'hEC10, 16'h0000);   // D=A shows new A
    step(1'b0, 16'h7FFF, 16'h0000);   // @32767
    step(1'b0, 16'hEA87, 16'h0000);   // 0;JMP
    step(1'b0, 16'hEC10, 16'h0000);   // non-jump at 32767
    step(1'b0, 16'hEC10, 16'h0000);   // pc wrapped to 0
    // Reset asserted mid-program with a writing instruction in flight
    step(1'b0, 16'h0064, 16'h0000);
    step(1'b1, 16'hFFFF, 16'hABCD);
    step(1'b0, 16'h0007, 16'h0000);
    // Randomized instructions with occasional resets
    for (int i = 0; i < 400; i++) begin
      ri = 16'($urandom);
      step(($urandom_range(0, 49) == 0), ri, 16'($urandom));
    end
    step(1'b0, 16'h0000, 16'h0000);
    for (int i = 0; i < 20 && scoreQ.size() > 0; i++) @(negedge clk);
    #1;
    if (scoreQ.size() > 0) begin
      numChecks++;
      numErrors++;
      $display("FAIL drain pending=%0d", scoreQ.size());
    end
    $display("Result: errors=%0d of %0d checks", numErrors, numChecks);
    $finish;
  end

endmodule
